// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Main-memory model answering a cache's memory-side requests.
//                Word-addressed storage, programmable access latency and
//                saturating read/write traffic counters.
//  Ports       : clk          - clock, rising edge
//                rst          - asynchronous reset, active low
//                addr         - word address (wraps modulo 2^DEPTH_BITS)
//                din          - write data
//                dout         - registered read data
//                re / we      - read / write request, sampled while ready=1
//                ready        - 1 = idle, previous access complete
//                read_count   - accepted reads, saturating
//                write_count  - accepted writes, saturating
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_WIDTH  = 64,
    parameter int WORD_WIDTH  = 64,
    parameter int DEPTH_BITS  = 10,
    parameter int LATENCY     = 4,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [WORD_WIDTH-1:0]  din,
    output logic [WORD_WIDTH-1:0]  dout,
    input  logic                   re,
    input  logic                   we,
    output logic                   ready,
    output logic [COUNT_WIDTH-1:0] read_count,
    output logic [COUNT_WIDTH-1:0] write_count
);

    localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_LAT_M1 = c_CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                  r_state;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_ready;
    logic [WORD_WIDTH-1:0]   r_dout;
    logic [COUNT_WIDTH-1:0]  r_read_count;
    logic [COUNT_WIDTH-1:0]  r_write_count;
    logic [DEPTH_BITS-1:0]   r_addr;
    logic [WORD_WIDTH-1:0]   r_din;
    logic                    r_op_read;

    // Storage is deliberately outside the reset domain: reset drops the
    // in-flight access but never clears memory contents.
    logic [WORD_WIDTH-1:0]   r_mem [0:(2**DEPTH_BITS)-1];

    logic [DEPTH_BITS-1:0]   w_idx;
    logic                    w_accept;
    logic                    w_complete;
    logic                    w_mem_we;
    logic [DEPTH_BITS-1:0]   w_mem_addr;
    logic [WORD_WIDTH-1:0]   w_mem_data;
    logic                    w_unused_addr;

    assign w_idx         = addr[DEPTH_BITS-1:0];
    assign w_unused_addr = ^addr[ADDR_WIDTH-1:DEPTH_BITS];
    assign w_accept      = (r_state == ST_IDLE) && (re || we);
    assign w_complete    = (r_state == ST_BUSY) && (r_cnt == '0);

    // Zero latency commits straight from the ports at the accept edge;
    // otherwise the latched request is committed on the completion edge.
    // A simultaneous read suppresses the write.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = r_addr;
        w_mem_data = r_din;
        if (LATENCY == 0) begin
            w_mem_we   = rst && w_accept && we && !re;
            w_mem_addr = w_idx;
            w_mem_data = din;
        end else begin
            w_mem_we   = rst && w_complete && !r_op_read;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_ready       <= 1'b1;
            r_dout        <= '0;
            r_read_count  <= '0;
            r_write_count <= '0;
            r_addr        <= '0;
            r_din         <= '0;
            r_op_read     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (re || we) begin
                        // Statistics move at acceptance, not completion.
                        if (re) begin
                            if (r_read_count != '1) begin
                                r_read_count <= r_read_count + 1'b1;
                            end
                        end else if (r_write_count != '1) begin
                            r_write_count <= r_write_count + 1'b1;
                        end
                        if (LATENCY == 0) begin
                            if (re) begin
                                r_dout <= r_mem[w_idx];
                            end
                        end else begin
                            r_state   <= ST_BUSY;
                            r_ready   <= 1'b0;
                            r_cnt     <= c_LAT_M1;
                            r_addr    <= w_idx;
                            r_din     <= din;
                            r_op_read <= re;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        if (r_op_read) begin
                            r_dout <= r_mem[r_addr];
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign dout        = r_dout;
    assign ready       = r_ready;
    assign read_count  = r_read_count;
    assign write_count = r_write_count;

endmodule
`default_nettype wire
